// File: rtl/nmp_pkg.sv
// Shared definitions for the near-memory processor: register offsets, opcodes,
// FSM states and the byte-strobe merge helper.
package nmp_pkg;

   localparam int MEM_BITS_DEF = 12;

   localparam logic [3:0] REG_OP          = 4'd0;
   localparam logic [3:0] REG_ADDR        = 4'd1;
   localparam logic [3:0] REG_STATUS      = 4'd2;
   localparam logic [3:0] REG_DATA_READ   = 4'd3;
   localparam logic [3:0] REG_DATA_WRITE  = 4'd4;
   localparam logic [3:0] REG_VECA        = 4'd5;
   localparam logic [3:0] REG_VECB        = 4'd6;
   localparam logic [3:0] REG_VECR        = 4'd7;
   localparam logic [3:0] REG_VEC_LEN     = 4'd8;
   localparam logic [3:0] REG_CYCLE_COUNT = 4'd9;

   localparam logic [31:0] OP_WAIT  = 32'd0;
   localparam logic [31:0] OP_READ  = 32'd1;
   localparam logic [31:0] OP_WRITE = 32'd2;
   localparam logic [31:0] OP_ADD   = 32'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_WR    = 3'd2,
      ST_ADD_A = 3'd3,
      ST_ADD_B = 3'd4,
      ST_ADD_W = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) begin
            res[8*i +: 8] = new_val[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_val[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/nmp_mem.sv
// Single-port synchronous 32-bit RAM, one-cycle read latency, contents not reset.
module nmp_mem
   import nmp_pkg::*;
#(
   parameter int MEM_BITS = MEM_BITS_DEF
) (
   input  logic                clk,
   input  logic                we,
   input  logic [MEM_BITS-1:0] addr,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata
);

   logic [31:0] mem_r [0:(2**MEM_BITS)-1];
   logic [31:0] rdata_r;

   // RAM array write port and registered read port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= wdata;
      end
      rdata_r <= mem_r[addr];
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/nmp_core.sv
// Near-memory processor: AXI4-Lite register file plus command FSM over nmp_mem.
// Optional read-only cycle counter at 0x24 enabled by NMP_CYCLE_COUNT_EN.
module nmp_core
   import nmp_pkg::*;
#(
   parameter int MEM_BITS           = MEM_BITS_DEF,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int C_S_AXI_DATA_WIDTH = 32
) (
   input  logic                            ACLK,
   input  logic                            ARESETn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY
);

   logic        awready_r, bvalid_r, arready_r, rvalid_r;
   logic [31:0] rdata_r, rd_mux_s;
   logic [31:0] op_r, addr_r, data_write_r, data_read_r;
   logic [31:0] veca_r, vecb_r, vecr_r, vec_len_r;
   logic        wr_hs_s, rd_hs_s;

   state_t              state_r, state_nx_s;
   logic                rd_phase_r, leave_idle_s;
   logic [31:0]         idx_r, len_r, cmd_data_r, a_val_r;
   logic [MEM_BITS-1:0] cmd_addr_r, a_base_r, b_base_r, r_base_r;
   logic [MEM_BITS-1:0] a_idx_s, b_idx_s, r_idx_s;
   logic                mem_we_s;
   logic [MEM_BITS-1:0] mem_addr_s;
   logic [31:0]         mem_wdata_s, mem_rdata_s;
   logic [1:0]          status_s;
   logic                unused_s;

   assign unused_s = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign wr_hs_s = awready_r & S_AXI_AWVALID & S_AXI_WVALID;
   assign rd_hs_s = arready_r & S_AXI_ARVALID;

   assign S_AXI_AWREADY = awready_r;
   assign S_AXI_WREADY  = awready_r;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_BVALID  = bvalid_r;
   assign S_AXI_ARREADY = arready_r;
   assign S_AXI_RDATA   = rdata_r;
   assign S_AXI_RRESP   = 2'b00;
   assign S_AXI_RVALID  = rvalid_r;

   // AXI handshakes and software-writable registers
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         awready_r <= 1'b0;  bvalid_r <= 1'b0;
         arready_r <= 1'b0;  rvalid_r <= 1'b0;  rdata_r <= 32'd0;
         op_r <= 32'd0;      addr_r <= 32'd0;   data_write_r <= 32'd0;
         veca_r <= 32'd0;    vecb_r <= 32'd0;   vecr_r <= 32'd0;  vec_len_r <= 32'd0;
      end else begin
         awready_r <= S_AXI_AWVALID & S_AXI_WVALID & ~awready_r & ~bvalid_r;
         arready_r <= S_AXI_ARVALID & ~arready_r & ~rvalid_r;
         if (wr_hs_s) begin
            bvalid_r <= 1'b1;
         end else if (S_AXI_BREADY) begin
            bvalid_r <= 1'b0;
         end
         if (rd_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_mux_s;
         end else if (S_AXI_RREADY) begin
            rvalid_r <= 1'b0;
         end
         if (wr_hs_s) begin
            case (S_AXI_AWADDR[5:2])
               REG_OP:         op_r         <= apply_strb(op_r, S_AXI_WDATA, S_AXI_WSTRB);
               REG_ADDR:       addr_r       <= apply_strb(addr_r, S_AXI_WDATA, S_AXI_WSTRB);
               REG_DATA_WRITE: data_write_r <= apply_strb(data_write_r, S_AXI_WDATA, S_AXI_WSTRB);
               REG_VECA:       veca_r       <= apply_strb(veca_r, S_AXI_WDATA, S_AXI_WSTRB);
               REG_VECB:       vecb_r       <= apply_strb(vecb_r, S_AXI_WDATA, S_AXI_WSTRB);
               REG_VECR:       vecr_r       <= apply_strb(vecr_r, S_AXI_WDATA, S_AXI_WSTRB);
               REG_VEC_LEN:    vec_len_r    <= apply_strb(vec_len_r, S_AXI_WDATA, S_AXI_WSTRB);
               default:        op_r         <= op_r;
            endcase
         end
      end
   end

`ifdef NMP_CYCLE_COUNT_EN
   logic [31:0] cycle_count_r;

   // Busy-cycle counter, cleared when a command starts and frozen afterwards
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         cycle_count_r <= 32'd0;
      end else if (leave_idle_s) begin
         cycle_count_r <= 32'd0;
      end else if (status_s[1]) begin
         cycle_count_r <= cycle_count_r + 32'd1;
      end
   end
`endif

   // Register read decode
   always_comb begin
      rd_mux_s = 32'd0;
      case (S_AXI_ARADDR[5:2])
         REG_OP:          rd_mux_s = op_r;
         REG_ADDR:        rd_mux_s = addr_r;
         REG_STATUS:      rd_mux_s = {30'd0, status_s};
         REG_DATA_READ:   rd_mux_s = data_read_r;
         REG_DATA_WRITE:  rd_mux_s = data_write_r;
         REG_VECA:        rd_mux_s = veca_r;
         REG_VECB:        rd_mux_s = vecb_r;
         REG_VECR:        rd_mux_s = vecr_r;
         REG_VEC_LEN:     rd_mux_s = vec_len_r;
`ifdef NMP_CYCLE_COUNT_EN
         REG_CYCLE_COUNT: rd_mux_s = cycle_count_r;
`else
         REG_CYCLE_COUNT: rd_mux_s = 32'd0;
`endif
         default:         rd_mux_s = 32'd0;
      endcase
   end

   assign a_idx_s = a_base_r + idx_r[MEM_BITS-1:0];
   assign b_idx_s = b_base_r + idx_r[MEM_BITS-1:0];
   assign r_idx_s = r_base_r + idx_r[MEM_BITS-1:0];
   assign leave_idle_s = (state_r == ST_IDLE) && (state_nx_s != ST_IDLE);

   // FSM next state, memory port control and status
   always_comb begin
      state_nx_s  = state_r;
      mem_we_s    = 1'b0;
      mem_addr_s  = {MEM_BITS{1'b0}};
      mem_wdata_s = 32'd0;
      status_s    = 2'b00;
      case (state_r)
         ST_IDLE: begin
            case (op_r)
               OP_WAIT:  state_nx_s = ST_IDLE;
               OP_READ:  state_nx_s = ST_RD;
               OP_WRITE: state_nx_s = ST_WR;
               OP_ADD:   state_nx_s = (vec_len_r == 32'd0) ? ST_DONE : ST_ADD_A;
               default:  state_nx_s = ST_DONE;
            endcase
         end
         ST_RD: begin
            status_s   = 2'b10;
            mem_addr_s = cmd_addr_r;
            state_nx_s = rd_phase_r ? ST_DONE : ST_RD;
         end
         ST_WR: begin
            status_s    = 2'b10;
            mem_we_s    = 1'b1;
            mem_addr_s  = cmd_addr_r;
            mem_wdata_s = cmd_data_r;
            state_nx_s  = ST_DONE;
         end
         ST_ADD_A: begin
            status_s   = 2'b10;
            mem_addr_s = a_idx_s;
            state_nx_s = ST_ADD_B;
         end
         ST_ADD_B: begin
            status_s   = 2'b10;
            mem_addr_s = b_idx_s;
            state_nx_s = ST_ADD_W;
         end
         ST_ADD_W: begin
            status_s    = 2'b10;
            mem_we_s    = 1'b1;
            mem_addr_s  = r_idx_s;
            mem_wdata_s = a_val_r + mem_rdata_s;
            state_nx_s  = ((idx_r + 32'd1) == len_r) ? ST_DONE : ST_ADD_A;
         end
         ST_DONE: begin
            status_s   = 2'b01;
            state_nx_s = (op_r == OP_WAIT) ? ST_IDLE : ST_DONE;
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // FSM state, operand snapshot and datapath registers
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_r    <= ST_IDLE;    rd_phase_r <= 1'b0;
         idx_r      <= 32'd0;      len_r      <= 32'd0;
         cmd_addr_r <= {MEM_BITS{1'b0}};  cmd_data_r <= 32'd0;
         a_base_r   <= {MEM_BITS{1'b0}};  b_base_r   <= {MEM_BITS{1'b0}};
         r_base_r   <= {MEM_BITS{1'b0}};  a_val_r    <= 32'd0;
         data_read_r <= 32'd0;
      end else begin
         state_r    <= state_nx_s;
         rd_phase_r <= (state_r == ST_RD) ? ~rd_phase_r : 1'b0;
         if (leave_idle_s) begin
            cmd_addr_r <= addr_r[MEM_BITS-1:0];
            cmd_data_r <= data_write_r;
            a_base_r   <= veca_r[MEM_BITS-1:0];
            b_base_r   <= vecb_r[MEM_BITS-1:0];
            r_base_r   <= vecr_r[MEM_BITS-1:0];
            len_r      <= vec_len_r;
         end
         if (state_r == ST_IDLE) begin
            idx_r <= 32'd0;
         end else if (state_r == ST_ADD_W) begin
            idx_r <= idx_r + 32'd1;
         end
         if ((state_r == ST_RD) && rd_phase_r) begin
            data_read_r <= mem_rdata_s;
         end
         if (state_r == ST_ADD_B) begin
            a_val_r <= mem_rdata_s;
         end
      end
   end

   nmp_mem #(.MEM_BITS(MEM_BITS)) u_mem (
      .clk   (ACLK),
      .we    (mem_we_s),
      .addr  (mem_addr_s),
      .wdata (mem_wdata_s),
      .rdata (mem_rdata_s)
   );

endmodule

// File: tb/tb_nmp_core.sv
// Directed self-checking bench for nmp_core through its AXI4-Lite port.
module tb_nmp_core;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic [5:0]  S_AXI_AWADDR = 6'd0;
   logic        S_AXI_AWVALID = 1'b0;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA = 32'd0;
   logic [3:0]  S_AXI_WSTRB = 4'd0;
   logic        S_AXI_WVALID = 1'b0;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY = 1'b0;
   logic [5:0]  S_AXI_ARADDR = 6'd0;
   logic        S_AXI_ARVALID = 1'b0;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY = 1'b0;

   int n_checks = 0;
   int n_fail = 0;

   int   cyc = 0;
   int   busy_start = 0, done_at = 0, op_hs_at = 0;
   logic prev_busy = 1'b0, prev_done = 1'b0;

   nmp_core dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
      .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
      .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
   );

   always #5 ACLK = ~ACLK;

   always @(posedge ACLK) cyc <= cyc + 1;

   // Timestamps (in posedge counts) of busy/done rising edges and op-register handshakes
   always @(negedge ACLK) begin
      if (dut.status_s[1] && !prev_busy) busy_start <= cyc;
      if (dut.status_s[0] && !prev_done) done_at <= cyc;
      if (S_AXI_AWVALID && S_AXI_AWREADY && S_AXI_AWADDR == 6'h00) op_hs_at <= cyc;
      prev_busy <= dut.status_s[1];
      prev_done <= dut.status_s[0];
   end

   task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
      int t;
      @(negedge ACLK);
      S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      t = 0;
      while (S_AXI_AWREADY !== 1'b1 && t < 100) begin @(negedge ACLK); t++; end
      if (t >= 100) begin n_checks++; n_fail++; $display("FAIL axi_write_aw timeout addr=%h", a); end
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
      t = 0;
      while (S_AXI_BVALID !== 1'b1 && t < 100) begin @(negedge ACLK); t++; end
      if (t >= 100) begin n_checks++; n_fail++; $display("FAIL axi_write_b timeout addr=%h", a); end
      @(negedge ACLK);
      S_AXI_BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
      int t;
      @(negedge ACLK);
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
      t = 0;
      while (S_AXI_ARREADY !== 1'b1 && t < 100) begin @(negedge ACLK); t++; end
      if (t >= 100) begin n_checks++; n_fail++; $display("FAIL axi_read_ar timeout addr=%h", a); end
      @(negedge ACLK);
      S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
      t = 0;
      while (S_AXI_RVALID !== 1'b1 && t < 100) begin @(negedge ACLK); t++; end
      if (t >= 100) begin n_checks++; n_fail++; $display("FAIL axi_read_r timeout addr=%h", a); end
      d = S_AXI_RDATA;
      @(negedge ACLK);
      S_AXI_RREADY = 1'b0;
   endtask

   task automatic wait_done();
      logic [31:0] st;
      int t;
      st = 32'd0; t = 0;
      while (st[0] !== 1'b1 && t < 5000) begin axi_read(6'h08, st); t++; end
      if (st[0] !== 1'b1) begin n_checks++; n_fail++; $display("FAIL wait_done timeout status=%h", st); end
   endtask

   task automatic mem_wr(input logic [31:0] a, input logic [31:0] d);
      axi_write(6'h04, a, 4'hF);
      axi_write(6'h10, d, 4'hF);
      axi_write(6'h00, 32'd2, 4'hF);
      wait_done();
      axi_write(6'h00, 32'd0, 4'hF);
   endtask

   task automatic mem_rd(input logic [31:0] a, output logic [31:0] d);
      axi_write(6'h04, a, 4'hF);
      axi_write(6'h00, 32'd1, 4'hF);
      wait_done();
      axi_read(6'h0C, d);
      axi_write(6'h00, 32'd0, 4'hF);
   endtask

   task automatic setup_add(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] r, input logic [31:0] len);
      axi_write(6'h14, a, 4'hF);
      axi_write(6'h18, b, 4'hF);
      axi_write(6'h1C, r, 4'hF);
      axi_write(6'h20, len, 4'hF);
   endtask

   task automatic run_add(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic [31:0] len);
      setup_add(a, b, r, len);
      axi_write(6'h00, 32'd3, 4'hF);
      wait_done();
      axi_write(6'h00, 32'd0, 4'hF);
   endtask

   task automatic test_reset();
      logic [31:0] v;
      axi_read(6'h00, v);
      if (v !== 32'd0) begin n_fail++; $display("FAIL reset_op got=%h exp=0", v); end
      n_checks++;
      axi_read(6'h08, v);
      if (v !== 32'd0) begin n_fail++; $display("FAIL reset_status got=%h exp=0", v); end
      n_checks++;
      axi_read(6'h0C, v);
      if (v !== 32'd0) begin n_fail++; $display("FAIL reset_data_read got=%h exp=0", v); end
      n_checks++;
      axi_read(6'h20, v);
      if (v !== 32'd0) begin n_fail++; $display("FAIL reset_vec_len got=%h exp=0", v); end
      n_checks++;
   endtask

   task automatic test_regs();
      logic [31:0] v;
      axi_write(6'h04, 32'h0000_1FFF, 4'hF);
      axi_read(6'h04, v);
      if (v !== 32'h0000_1FFF) begin n_fail++; $display("FAIL reg_addr got=%h exp=00001fff", v); end
      n_checks++;
      axi_write(6'h10, 32'hAABB_CCDD, 4'hF);
      axi_write(6'h10, 32'h1122_3344, 4'b0101);
      axi_read(6'h10, v);
      if (v !== 32'hAA22_CC44) begin n_fail++; $display("FAIL reg_wstrb got=%h exp=aa22cc44", v); end
      n_checks++;
      axi_write(6'h28, 32'hDEAD_BEEF, 4'hF);
      axi_read(6'h28, v);
      if (v !== 32'd0) begin n_fail++; $display("FAIL reg_unmapped got=%h exp=0", v); end
      n_checks++;
      axi_write(6'h08, 32'hFFFF_FFFF, 4'hF);
      axi_read(6'h08, v);
      if (v !== 32'd0) begin n_fail++; $display("FAIL reg_status_ro got=%h exp=0", v); end
      n_checks++;
`ifndef NMP_CYCLE_COUNT_EN
      axi_read(6'h24, v);
      if (v !== 32'd0) begin n_fail++; $display("FAIL reg_cycle_count_off got=%h exp=0", v); end
      n_checks++;
`endif
      // An unknown opcode completes with no side effect
      axi_write(6'h00, 32'd7, 4'hF);
      wait_done();
      axi_read(6'h08, v);
      if (v !== 32'd1) begin n_fail++; $display("FAIL unknown_op_status got=%h exp=1", v); end
      n_checks++;
      axi_write(6'h00, 32'd0, 4'hF);
      axi_read(6'h08, v);
      if (v !== 32'd0) begin n_fail++; $display("FAIL unknown_op_clear got=%h exp=0", v); end
      n_checks++;
   endtask

   task automatic test_sanity();
      logic [31:0] v;
      mem_wr(32'd2, 32'd16);
      mem_wr(32'd4, 32'd32);
      setup_add(32'd2, 32'd4, 32'd8, 32'd1);
      axi_write(6'h00, 32'd3, 4'hF);
      wait_done();
      axi_read(6'h08, v);
      if (v !== 32'd1) begin n_fail++; $display("FAIL sanity_done got=%h exp=1", v); end
      n_checks++;
      axi_write(6'h00, 32'd0, 4'hF);
      axi_read(6'h08, v);
      if (v !== 32'd0) begin n_fail++; $display("FAIL sanity_done_clear got=%h exp=0", v); end
      n_checks++;
      mem_rd(32'd8, v);
      if (v !== 32'd48) begin n_fail++; $display("FAIL sanity_sum got=%0d exp=48", v); end
      n_checks++;
      mem_rd(32'd2, v);
      if (v !== 32'd16) begin n_fail++; $display("FAIL sanity_src got=%0d exp=16", v); end
      n_checks++;
   endtask

   task automatic test_overflow();
      logic [31:0] v;
      mem_wr(32'd0, 32'hFFFF_FFFF);
      mem_wr(32'd1365, 32'd1);
      mem_wr(32'd2730, 32'h5555_5555);
      run_add(32'd0, 32'd1365, 32'd2730, 32'd1);
      mem_rd(32'd2730, v);
      if (v !== 32'd0) begin n_fail++; $display("FAIL overflow_sum got=%h exp=0", v); end
      n_checks++;
   endtask

   task automatic test_vectors();
      logic [31:0] av [5];
      logic [31:0] bv [5];
      logic [31:0] ev [5];
      logic [31:0] ra [8];
      logic [31:0] rb [8];
      logic [31:0] v;
      av = '{32'd1, 32'd2, 32'd3, 32'h7FFF_FFFF, 32'h8000_0000};
      bv = '{32'd10, 32'd20, 32'd30, 32'd1, 32'h8000_0000};
      ev = '{32'd11, 32'd22, 32'd33, 32'h8000_0000, 32'd0};
      for (int i = 0; i < 5; i++) begin
         mem_wr(32'd100 + i, av[i]);
         mem_wr(32'd200 + i, bv[i]);
      end
      run_add(32'd100, 32'd200, 32'd300, 32'd5);
      for (int i = 0; i < 5; i++) begin
         mem_rd(32'd300 + i, v);
         if (v !== ev[i]) begin n_fail++; $display("FAIL vec_sum[%0d] got=%h exp=%h", i, v, ev[i]); end
         n_checks++;
      end
      // Random operands in disjoint thirds of memory
      for (int i = 0; i < 8; i++) begin
         ra[i] = $urandom;
         rb[i] = $urandom;
         mem_wr(32'd1000 + i, ra[i]);
         mem_wr(32'd2000 + i, rb[i]);
      end
      run_add(32'd1000, 32'd2000, 32'd3000, 32'd8);
      for (int i = 0; i < 8; i++) begin
         mem_rd(32'd3000 + i, v);
         if (v !== ra[i] + rb[i]) begin
            n_fail++; $display("FAIL rand_sum[%0d] got=%h exp=%h", i, v, ra[i] + rb[i]);
         end
         n_checks++;
      end
      // r = a + 1: each element sees the previous element's fresh result
      for (int i = 0; i < 4; i++) mem_wr(32'd400 + i, 32'd1 + i);
      for (int i = 0; i < 3; i++) mem_wr(32'd500 + i, 32'd10);
      run_add(32'd400, 32'd500, 32'd401, 32'd3);
      mem_rd(32'd401, v);
      if (v !== 32'd11) begin n_fail++; $display("FAIL overlap_first got=%0d exp=11", v); end
      n_checks++;
      mem_rd(32'd403, v);
      if (v !== 32'd31) begin n_fail++; $display("FAIL overlap_last got=%0d exp=31", v); end
      n_checks++;
   endtask

   task automatic test_latency();
      logic [31:0] v;
      int len;
      for (int k = 0; k <= 10; k++) begin
         len = 1 << k;
         setup_add(32'd0, 32'd1024, 32'd2048, len);
         axi_write(6'h00, 32'd3, 4'hF);
         wait_done();
         if (done_at - busy_start !== 3 * len) begin
            n_fail++; $display("FAIL latency_len%0d got=%0d exp=%0d", len, done_at - busy_start, 3 * len);
         end
         n_checks++;
`ifdef NMP_CYCLE_COUNT_EN
         axi_read(6'h24, v);
         if (v !== 3 * len) begin n_fail++; $display("FAIL cycle_count_len%0d got=%0d exp=%0d", len, v, 3 * len); end
         n_checks++;
`endif
         axi_write(6'h00, 32'd0, 4'hF);
      end
      // len 0: op register updates one edge after the handshake, done the cycle after that
      mem_wr(32'd3500, 32'h0000_CAFE);
      setup_add(32'd0, 32'd1024, 32'd3500, 32'd0);
      axi_write(6'h00, 32'd3, 4'hF);
      wait_done();
      if (done_at - op_hs_at !== 2) begin
         n_fail++; $display("FAIL latency_len0 got=%0d exp=2", done_at - op_hs_at);
      end
      n_checks++;
      axi_write(6'h00, 32'd0, 4'hF);
      mem_rd(32'd3500, v);
      if (v !== 32'h0000_CAFE) begin n_fail++; $display("FAIL len0_mem got=%h exp=0000cafe", v); end
      n_checks++;
   endtask

   task automatic test_addr_wrap();
      logic [31:0] v;
      mem_wr(32'd4095, 32'd7);
      mem_rd(32'h0000_1FFF, v);
      if (v !== 32'd7) begin n_fail++; $display("FAIL addr_wrap got=%0d exp=7", v); end
      n_checks++;
   endtask

   task automatic test_reset_mid_add();
      logic [31:0] v;
      mem_wr(32'd50, 32'h1234_5678);
      setup_add(32'd1000, 32'd2000, 32'd3000, 32'd1000);
      axi_write(6'h00, 32'd3, 4'hF);
      repeat (100) @(negedge ACLK);
      ARESETn = 1'b0;
      repeat (2) @(negedge ACLK);
      ARESETn = 1'b1;
      @(negedge ACLK);
      axi_read(6'h08, v);
      if (v !== 32'd0) begin n_fail++; $display("FAIL midreset_status got=%h exp=0", v); end
      n_checks++;
      axi_read(6'h00, v);
      if (v !== 32'd0) begin n_fail++; $display("FAIL midreset_op got=%h exp=0", v); end
      n_checks++;
      mem_rd(32'd50, v);
      if (v !== 32'h1234_5678) begin n_fail++; $display("FAIL midreset_mem got=%h exp=12345678", v); end
      n_checks++;
   endtask

   initial begin
      ARESETn = 1'b0;
      repeat (3) @(negedge ACLK);
      ARESETn = 1'b1;
      test_reset();
      test_regs();
      test_sanity();
      test_overflow();
      test_vectors();
      test_addr_wrap();
      test_latency();
      test_reset_mid_add();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
